// File: rtl/uart_pkg.sv
// Shared UART definitions for the response transmitter and command receiver.
// Holds the sequencer state type, frame length and default baud divisor.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        WAIT_HIGH,
        WAIT_LOW
    } tx_state_t;

    localparam int UART_FRAME_BITS  = 10;
    localparam int DEFAULT_BAUD_DIV = 2604;

endpackage

// File: rtl/uart_tx_byte.sv
// Byte-level UART transmitter: start bit, 8 data bits LSB first, stop bit.
// Ports: clk, rst_n, trmt (load+start), tx_data, TX (serial out), tx_done.
module uart_tx_byte
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       TX,
    output logic       tx_done
);

    localparam logic [11:0] BAUD_LAST = 12'(BAUD_DIV - 1);
    localparam logic [11:0] BAUD_PRE  = 12'(BAUD_DIV - 2);
    localparam logic [3:0]  LAST_BIT  = 4'(UART_FRAME_BITS - 1);

    logic [8:0]  shift_reg;
    logic [11:0] baud_cnt;
    logic [3:0]  bit_cnt;
    logic        running;
    logic        baud_tc;

    assign baud_tc = (baud_cnt == BAUD_LAST);

    // The line is the shifter LSB, so TX comes straight from a flop.
    assign TX = shift_reg[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '1;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            running   <= 1'b0;
            tx_done   <= 1'b0;
        end else if (trmt) begin
            shift_reg <= {tx_data, 1'b0};
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            running   <= 1'b1;
            tx_done   <= 1'b0;
        end else if (running) begin
            // Done is raised one cycle before the stop bit ends so the
            // sequencer can act on the very edge the stop bit completes.
            if (bit_cnt == LAST_BIT && baud_cnt == BAUD_PRE) begin
                tx_done <= 1'b1;
            end
            if (baud_tc) begin
                baud_cnt  <= '0;
                shift_reg <= {1'b1, shift_reg[8:1]};
                bit_cnt   <= bit_cnt + 4'd1;
                if (bit_cnt == LAST_BIT) begin
                    running <= 1'b0;
                end
            end else begin
                baud_cnt <= baud_cnt + 12'd1;
            end
        end
    end

endmodule

// File: rtl/uart_resp_tx.sv
// Sends a 16-bit response as two UART frames, high byte first.
// Ports: clk, rst_n, snd_resp, resp[15:0], TX, busy, resp_sent.
module uart_resp_tx
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        snd_resp,
    input  logic [15:0] resp,
    output logic        TX,
    output logic        busy,
    output logic        resp_sent
);

    tx_state_t   state;
    tx_state_t   state_nxt;
    logic [15:0] resp_hold;
    logic [7:0]  tx_data;
    logic        trmt;
    logic        trmt_nxt;
    logic        load;
    logic        finish;
    logic        tx_done;

    // Registered trmt: it is high for the one cycle following the
    // decision, which places the byte start one cycle after acceptance
    // and inserts the single idle cycle between the two frames.
    always_comb begin
        state_nxt = state;
        trmt_nxt  = 1'b0;
        load      = 1'b0;
        finish    = 1'b0;
        unique case (state)
            IDLE: begin
                if (snd_resp) begin
                    load      = 1'b1;
                    trmt_nxt  = 1'b1;
                    state_nxt = HIGH;
                end
            end
            HIGH: begin
                state_nxt = WAIT_HIGH;
            end
            WAIT_HIGH: begin
                if (tx_done) begin
                    trmt_nxt  = 1'b1;
                    state_nxt = WAIT_LOW;
                end
            end
            WAIT_LOW: begin
                // tx_done is stale while the low byte is being loaded.
                if (tx_done && !trmt) begin
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            trmt      <= 1'b0;
            resp_hold <= '0;
            busy      <= 1'b0;
            resp_sent <= 1'b0;
        end else begin
            state <= state_nxt;
            trmt  <= trmt_nxt;
            if (load) begin
                resp_hold <= resp;
                busy      <= 1'b1;
                resp_sent <= 1'b0;
            end
            if (finish) begin
                busy      <= 1'b0;
                resp_sent <= 1'b1;
            end
        end
    end

    assign tx_data = (state == HIGH) ? resp_hold[15:8] : resp_hold[7:0];

    uart_tx_byte #(
        .BAUD_DIV (BAUD_DIV)
    ) u_tx_byte (
        .clk     (clk),
        .rst_n   (rst_n),
        .trmt    (trmt),
        .tx_data (tx_data),
        .TX      (TX),
        .tx_done (tx_done)
    );

endmodule

// File: tb/tb_uart_resp_tx.sv
// Bench for uart_resp_tx: frame decoder with byte scoreboard plus
// per-scenario timing checks at BAUD_DIV=16.
module tb_uart_resp_tx;

    localparam int D   = 16;
    localparam int LAT = 2 + 20 * D;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        snd_resp = 1'b0;
    logic [15:0] resp = '0;
    logic        TX;
    logic        busy;
    logic        resp_sent;

    int errors = 0;
    int checks = 0;
    int frames = 0;
    bit mon_discard = 1'b0;
    logic [7:0] sb[$];
    logic tx_log [0:LAT];

    always #5 clk = ~clk;

    uart_resp_tx #(.BAUD_DIV(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .snd_resp  (snd_resp),
        .resp      (resp),
        .TX        (TX),
        .busy      (busy),
        .resp_sent (resp_sent)
    );

    // Frame decoder: samples mid-bit and compares against the scoreboard.
    always begin : monitor
        logic       s0;
        logic       sp;
        logic [7:0] d;
        logic [7:0] e;
        @(negedge clk);
        if (rst_n === 1'b1 && TX === 1'b0) begin
            repeat (8) @(negedge clk);
            s0 = TX;
            for (int b = 0; b < 8; b++) begin
                repeat (D) @(negedge clk);
                d[b] = TX;
            end
            repeat (D) @(negedge clk);
            sp = TX;
            if (!mon_discard) begin
                frames++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL frame: unexpected byte %h", d);
                end else begin
                    e = sb.pop_front();
                    if ({sp, d, s0} !== {1'b1, e, 1'b0}) begin
                        errors++;
                        $display("FAIL frame: got start=%b data=%h stop=%b, want data=%h",
                                 s0, d, sp, e);
                    end
                end
            end
        end
    end

    task automatic send(input logic [15:0] v);
        @(posedge clk); #1;
        snd_resp = 1'b1;
        resp     = v;
        @(posedge clk); #1;
        snd_resp = 1'b0;
    endtask

    task automatic test_reset;
        int lows;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({TX, busy, resp_sent} !== 3'b100) begin
            errors++;
            $display("FAIL reset_hold: got %b want 100", {TX, busy, resp_sent});
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({TX, busy, resp_sent} !== 3'b100) begin
            errors++;
            $display("FAIL reset_release: got %b want 100", {TX, busy, resp_sent});
        end
        lows = 0;
        repeat (100) begin
            @(posedge clk); #1;
            if (TX !== 1'b1) lows++;
        end
        checks++;
        if (lows !== 0) begin
            errors++;
            $display("FAIL idle_line: got %0d low cycles want 0", lows);
        end
    endtask

    task automatic test_single;
        int   n;
        int   f0;
        logic bprev;
        f0 = frames;
        sb.push_back(8'hA5);
        sb.push_back(8'h5A);
        send(16'hA55A);
        checks++;
        if ({busy, resp_sent} !== 2'b10) begin
            errors++;
            $display("FAIL single_accept: got %b want 10", {busy, resp_sent});
        end
        n = 0;
        bprev = 1'b1;
        while (n < 1000) begin
            @(posedge clk); #1;
            n++;
            if (resp_sent === 1'b1) break;
            bprev = busy;
        end
        checks++;
        if (n !== LAT) begin
            errors++;
            $display("FAIL single_latency: got %0d want %0d", n, LAT);
        end
        checks++;
        if ({bprev, busy} !== 2'b10) begin
            errors++;
            $display("FAIL single_busy_fall: got %b want 10", {bprev, busy});
        end
        repeat (20) @(posedge clk);
        checks++;
        if (frames - f0 !== 2 || sb.size() !== 0) begin
            errors++;
            $display("FAIL single_frames: got %0d left %0d want 2 left 0",
                     frames - f0, sb.size());
        end
    endtask

    task automatic test_bit_timing;
        int run;
        int ones;
        sb.push_back(8'h00);
        sb.push_back(8'hFF);
        send(16'h00FF);
        for (int i = 1; i <= LAT; i++) begin
            @(posedge clk); #1;
            tx_log[i] = TX;
        end
        run = 0;
        while (run < LAT && tx_log[1 + run] === 1'b0) run++;
        checks++;
        if (run !== 9 * D) begin
            errors++;
            $display("FAIL high_low_run: got %0d want %0d", run, 9 * D);
        end
        run = 0;
        while (run < 40 && tx_log[1 + 9 * D + run] === 1'b1) run++;
        checks++;
        if (run !== D + 1) begin
            errors++;
            $display("FAIL stop_gap: got %0d want %0d", run, D + 1);
        end
        run = 0;
        while (run < 40 && tx_log[2 + 10 * D + run] === 1'b0) run++;
        checks++;
        if (run !== D) begin
            errors++;
            $display("FAIL low_start: got %0d want %0d", run, D);
        end
        ones = 0;
        for (int i = 2 + 11 * D; i < 2 + 19 * D; i++) begin
            if (tx_log[i] === 1'b1) ones++;
        end
        checks++;
        if (ones !== 8 * D) begin
            errors++;
            $display("FAIL data_ones: got %0d want %0d", ones, 8 * D);
        end
        checks++;
        if (resp_sent !== 1'b1) begin
            errors++;
            $display("FAIL timing_sent: got %b want 1", resp_sent);
        end
        repeat (20) @(posedge clk);
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL timing_frames: got %0d left want 0", sb.size());
        end
    endtask

    task automatic test_busy_ignore;
        int n;
        int f0;
        int bhi;
        f0 = frames;
        sb.push_back(8'h12);
        sb.push_back(8'h34);
        send(16'h1234);
        n = 0;
        while (n < 1000) begin
            @(posedge clk); #1;
            n++;
            snd_resp = (n == 50);
            if (n == 50) resp = 16'hFFFF;
            if (resp_sent === 1'b1) break;
        end
        snd_resp = 1'b0;
        checks++;
        if (n !== LAT) begin
            errors++;
            $display("FAIL ignore_latency: got %0d want %0d", n, LAT);
        end
        bhi = 0;
        repeat (400) begin
            @(posedge clk); #1;
            if (busy !== 1'b0 || resp_sent !== 1'b1) bhi++;
        end
        checks++;
        if (bhi !== 0) begin
            errors++;
            $display("FAIL ignore_no_retx: got %0d busy cycles want 0", bhi);
        end
        checks++;
        if (frames - f0 !== 2 || sb.size() !== 0) begin
            errors++;
            $display("FAIL ignore_frames: got %0d left %0d want 2 left 0",
                     frames - f0, sb.size());
        end
    endtask

    task automatic test_back_to_back;
        int n;
        int f0;
        int first_low;
        f0 = frames;
        sb.push_back(8'hCA);
        sb.push_back(8'hFE);
        send(16'hCAFE);
        n = 0;
        while (n < 1000) begin
            @(posedge clk); #1;
            n++;
            if (resp_sent === 1'b1) break;
        end
        checks++;
        if (n !== LAT) begin
            errors++;
            $display("FAIL b2b_first_latency: got %0d want %0d", n, LAT);
        end
        snd_resp = 1'b1;
        resp     = 16'hBEEF;
        sb.push_back(8'hBE);
        sb.push_back(8'hEF);
        @(posedge clk); #1;
        snd_resp = 1'b0;
        checks++;
        if ({busy, resp_sent} !== 2'b10) begin
            errors++;
            $display("FAIL b2b_accept: got %b want 10", {busy, resp_sent});
        end
        n = 0;
        first_low = -1;
        while (n < 1000) begin
            @(posedge clk); #1;
            n++;
            if (first_low < 0 && TX === 1'b0) first_low = n;
            if (resp_sent === 1'b1) break;
        end
        checks++;
        if (first_low !== 1) begin
            errors++;
            $display("FAIL b2b_start: got %0d want 1", first_low);
        end
        checks++;
        if (n !== LAT) begin
            errors++;
            $display("FAIL b2b_latency: got %0d want %0d", n, LAT);
        end
        repeat (20) @(posedge clk);
        checks++;
        if (frames - f0 !== 4 || sb.size() !== 0) begin
            errors++;
            $display("FAIL b2b_frames: got %0d left %0d want 4 left 0",
                     frames - f0, sb.size());
        end
    endtask

    task automatic test_reset_mid;
        int n;
        int f0;
        int bad;
        mon_discard = 1'b1;
        send(16'h8000);
        repeat (100) @(posedge clk);
        #1;
        checks++;
        if (TX !== 1'b0) begin
            errors++;
            $display("FAIL mid_pre_tx: got %b want 0", TX);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({TX, busy, resp_sent} !== 3'b100) begin
            errors++;
            $display("FAIL mid_async: got %b want 100", {TX, busy, resp_sent});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        bad = 0;
        repeat (200) begin
            @(posedge clk); #1;
            if (TX !== 1'b1 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL mid_quiet: got %0d bad cycles want 0", bad);
        end
        sb.delete();
        mon_discard = 1'b0;
        f0 = frames;
        sb.push_back(8'h00);
        sb.push_back(8'h01);
        send(16'h0001);
        n = 0;
        while (n < 1000) begin
            @(posedge clk); #1;
            n++;
            if (resp_sent === 1'b1) break;
        end
        checks++;
        if (n !== LAT) begin
            errors++;
            $display("FAIL mid_latency: got %0d want %0d", n, LAT);
        end
        repeat (20) @(posedge clk);
        checks++;
        if (frames - f0 !== 2 || sb.size() !== 0) begin
            errors++;
            $display("FAIL mid_frames: got %0d left %0d want 2 left 0",
                     frames - f0, sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_bit_timing();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
